// File: rtl/master_traffic_gen_if.sv
// Request/acknowledge bus between one traffic-generator master and a
// cross-bar master port. The master drives the request side; the slave
// answers with ack and, the cycle after a read ack, rdata.
interface master_traffic_gen_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              master_req;
    logic [ADDR_W-1:0] master_addr;
    logic              master_cmd;
    logic [DATA_W-1:0] master_wdata;
    logic              master_ack;
    logic [DATA_W-1:0] master_rdata;

    modport master (
        output master_req, master_addr, master_cmd, master_wdata,
        input  master_ack, master_rdata
    );

    modport slave (
        input  master_req, master_addr, master_cmd, master_wdata,
        output master_ack, master_rdata
    );
endinterface

// File: rtl/master_traffic_gen.sv
// Seeded traffic generator: issues a programmed number of single-outstanding
// transactions (write, read, mixed, or write-then-readback) and reports
// completion, readback errors and ack timeouts.
module master_traffic_gen #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 32,
    parameter int          MEM_DEPTH = 32,
    parameter int          SEL_BITS  = 1,
    parameter int          NUM_TRANS = 64,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] trans_cnt,
    output logic [15:0] err_cnt,
    master_traffic_gen_if.master bus
);
    localparam int          IDX_W    = $clog2(MEM_DEPTH);
    localparam int          TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [31:0] SEED_EFF = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam logic [31:0] TAPS     = 32'h8020_0003;
    localparam logic [15:0] NUM_TR   = 16'(NUM_TRANS);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RDATA,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [31:0]       lfsr_reg;
    logic [1:0]        mode_reg;
    logic              rd_phase_reg;   // mode 3: next generated transaction is the readback
    logic [ADDR_W-1:0] addr_reg;
    logic              cmd_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic [15:0]       trans_cnt_reg;
    logic [15:0]       err_cnt_reg;
    logic              timeout_reg;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // FSM strobes
    logic start_acc, gen_en, cnt_inc, rd_cap, to_fire;

    // Generation datapath
    logic [1:0]        gen_mode;
    logic              gen_rd3;
    logic [31:0]       lfsr_step;
    logic [31:0]       gen_lfsr;
    logic [IDX_W-1:0]  gen_idx;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_cmd;
    logic [DATA_W-1:0] gen_wdata;
    logic [DATA_W-1:0] lfsr_rep;

    // Local memory write port
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // LFSR value replicated across the data bus for wide DATA_W
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rep
            assign lfsr_rep[gi] = gen_lfsr[gi % 32];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_next = state_reg;
        start_acc  = 1'b0;
        gen_en     = 1'b0;
        cnt_inc    = 1'b0;
        rd_cap     = 1'b0;
        to_fire    = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    if (NUM_TR == 16'd0) begin
                        state_next = S_DONE;
                    end else begin
                        gen_en     = 1'b1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (bus.master_ack) begin
                    if (cmd_reg) begin
                        cnt_inc    = 1'b1;
                        state_next = S_GAP;
                    end else begin
                        state_next = S_RDATA;
                    end
                end else if (to_cnt_reg == TO_LAST) begin
                    to_fire    = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_RDATA: begin
                rd_cap     = 1'b1;
                cnt_inc    = 1'b1;
                state_next = S_GAP;
            end
            S_GAP: begin
                if (trans_cnt_reg == NUM_TR) begin
                    state_next = S_DONE;
                end else begin
                    gen_en     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Next transaction derived from the LFSR; the readback half of a mode-3
    // pair reuses the current LFSR so it targets the address just written
    always_comb begin
        gen_mode  = start_acc ? mode : mode_reg;
        gen_rd3   = (gen_mode == 2'd3) && !start_acc && rd_phase_reg;
        lfsr_step = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ TAPS) : (lfsr_reg >> 1);
        gen_lfsr  = gen_rd3 ? lfsr_reg : lfsr_step;
        gen_idx   = gen_lfsr[IDX_W+SEL_BITS-1:SEL_BITS];
        gen_addr  = '0;
        gen_addr[ADDR_W-1 -: SEL_BITS] = gen_lfsr[SEL_BITS-1:0];
        gen_addr[IDX_W-1:0]            = gen_idx;
        case (gen_mode)
            2'd0:    gen_cmd = 1'b1;
            2'd1:    gen_cmd = 1'b0;
            2'd2:    gen_cmd = gen_lfsr[31];
            default: gen_cmd = !gen_rd3;
        endcase
        if (!gen_cmd) begin
            gen_wdata = '0;
        end else if (gen_mode == 2'd3) begin
            gen_wdata = lfsr_rep;
        end else begin
            gen_wdata = mem[gen_idx];
        end
    end

    // Local memory write selection: mode-3 write value at generation time,
    // captured read data in modes 1/2
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = gen_idx;
        mem_wdata = lfsr_rep;
        if (gen_en && (gen_mode == 2'd3) && !gen_rd3) begin
            mem_we = 1'b1;
        end else if (rd_cap && ((mode_reg == 2'd1) || (mode_reg == 2'd2))) begin
            mem_we    = 1'b1;
            mem_waddr = idx_reg;
            mem_wdata = bus.master_rdata;
        end
    end

    // Transaction registers, counters and local memory
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lfsr_reg      <= SEED_EFF;
            mode_reg      <= 2'd0;
            rd_phase_reg  <= 1'b0;
            addr_reg      <= '0;
            cmd_reg       <= 1'b0;
            wdata_reg     <= '0;
            idx_reg       <= '0;
            to_cnt_reg    <= '0;
            trans_cnt_reg <= 16'd0;
            err_cnt_reg   <= 16'd0;
            timeout_reg   <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else begin
            if (start_acc) begin
                mode_reg      <= mode;
                trans_cnt_reg <= 16'd0;
                err_cnt_reg   <= 16'd0;
                timeout_reg   <= 1'b0;
            end
            if (gen_en) begin
                lfsr_reg     <= gen_lfsr;
                addr_reg     <= gen_addr;
                cmd_reg      <= gen_cmd;
                wdata_reg    <= gen_wdata;
                idx_reg      <= gen_idx;
                rd_phase_reg <= (gen_mode == 2'd3) && !gen_rd3;
                to_cnt_reg   <= '0;
            end else if (state_reg == S_ISSUE) begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end
            if (cnt_inc) begin
                trans_cnt_reg <= trans_cnt_reg + 16'd1;
            end
            if (to_fire) begin
                timeout_reg <= 1'b1;
            end
            if (rd_cap && (mode_reg == 2'd3) && (bus.master_rdata != mem[idx_reg])
                    && (err_cnt_reg != 16'hFFFF)) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
            if (mem_we) begin
                mem[mem_waddr] <= mem_wdata;
            end
        end
    end

    assign bus.master_req   = (state_reg == S_ISSUE);
    assign bus.master_addr  = addr_reg;
    assign bus.master_cmd   = cmd_reg;
    assign bus.master_wdata = wdata_reg;

    assign busy      = (state_reg == S_ISSUE) || (state_reg == S_RDATA) || (state_reg == S_GAP);
    assign done      = (state_reg == S_DONE);
    assign timeout   = timeout_reg;
    assign trans_cnt = trans_cnt_reg;
    assign err_cnt   = err_cnt_reg;
endmodule

// File: doc/master_traffic_gen.md
Name: master_traffic_gen

Overview:
- Parametrised test-master / traffic generator for the cross-bar benches; one instance drives one cross-bar master port.
- Issues a programmed number of single-outstanding transactions through the req/ack interface.
- Four modes: write-only, read-only, random mixed, write-then-readback self-check.
- Addresses, commands and data are generated by a seeded LFSR, so runs are reproducible; error, timeout and status counters are reported.

Parameters:
DATA_W, 32, data bus width.
ADDR_W, 32, address bus width.
MEM_DEPTH, 32, local memory words; power of 2, >=2.
SEL_BITS, 1, slave-select bits at addr[ADDR_W-1 -: SEL_BITS].
NUM_TRANS, 64, completed transactions per run (0..65535).
TIMEOUT, 255, max cycles waiting for ack (>=1).
LFSR_SEED, 32'hACE1_2468, LFSR reset value; 0 is replaced by 1.

Ports:
clk  in  1  single clock, rising edge.
resetn  in  1  synchronous active-low reset.
start  in  1  one-cycle run request, sampled in IDLE or DONE.
mode  in  2  0 write, 1 read, 2 mixed, 3 write-readback; sampled at start.
busy  out  1  high from start accept until DONE.
done  out  1  high while in DONE.
timeout  out  1  sticky; an ack wait exceeded TIMEOUT.
trans_cnt  out  16  completed transactions this run.
err_cnt  out  16  readback mismatches this run (mode 3), saturating.
master_req  out  1  request.
master_addr  out  ADDR_W  address.
master_cmd  out  1  1 = write, 0 = read.
master_wdata  out  DATA_W  write data.
master_ack  in  1  slave accept.
master_rdata  in  DATA_W  read data, valid the cycle after a read ack.

Behaviour:
- Reset (resetn=0 at clk edge): all outputs 0; FSM IDLE; LFSR=LFSR_SEED; mem[i]=i (zero-extended); timeout counter 0. Reset wins over every other event; mid-transaction reset drops req on that edge.
- FSM states IDLE, ISSUE, RDATA, GAP, DONE.
- IDLE/DONE + start: clear trans_cnt, err_cnt, timeout; latch mode; busy=1, done=0.
  - NUM_TRANS=0: enter DONE next cycle.
  - Otherwise generate a transaction and enter ISSUE.
  - start is ignored while busy.
- Generation: the LFSR advances once per generated transaction (Galois, 32-bit, taps 0x80200003).
  - sel = LFSR[SEL_BITS-1:0]; idx = LFSR[log2(MEM_DEPTH)+SEL_BITS-1:SEL_BITS].
  - addr = {sel, zeros, idx}.
  - cmd: mode0 → 1; mode1 → 0; mode2 → LFSR[31].
  - Mode 3 alternates: the write uses a new address with wdata = LFSR[DATA_W-1:0] (replicated if DATA_W>32), and that value is stored in mem[idx]. The following read uses the same address and does not advance the LFSR.
  - Modes 0/2 writes: wdata = mem[idx].
- wdata is 0 whenever cmd=0.
- ISSUE: req=1; addr, cmd and wdata are held stable until ack is sampled high.
  - Write ack: trans_cnt++ and go to GAP.
  - Read ack: go to RDATA.
- RDATA (req=0): capture rdata and trans_cnt++.
  - Modes 1/2: mem[idx] <= rdata.
  - Mode 3: compare rdata with mem[idx]; on mismatch err_cnt++ (saturates at 16'hFFFF); mem is unchanged.
  - Then go to GAP.
- GAP: req=0 for exactly one cycle.
  - trans_cnt == NUM_TRANS: go to DONE (busy=0, done=1).
  - Otherwise generate the next transaction and go to ISSUE.
- Throughput: one write every 2 cycles with zero-wait ack; one read every 3 cycles.
- Ack while req=0 is ignored.
- Timeout: a counter runs while in ISSUE and resets on each new ISSUE entry. If the count reaches TIMEOUT with no ack: req=0, timeout=1, go to DONE. The stalled transaction is not counted.
- In mode 3 NUM_TRANS counts writes and reads individually. If NUM_TRANS is odd, the run ends after a write.
- Transaction generation is independent of ack timing: same seed and mode give an identical address/cmd/wdata sequence.

Test Plan:
- Reset → req=0, busy=0, done=0, trans_cnt=0, err_cnt=0, timeout=0; assert resetn=0 for one cycle mid-ISSUE → req=0 next edge, FSM IDLE.
- Mode 0, NUM_TRANS=4, slave acks 2 cycles after req → 4 writes with cmd=1, req low one cycle between each, trans_cnt=4, done=1, busy=0.
- Mode 1, NUM_TRANS=3, slave returns rdata=32'hDEAD_0000+addr → local mem updated at each idx; each read takes 3 cycles with zero-wait ack.
- Mode 3, NUM_TRANS=8, echo-memory slave → 4 write/read pairs to matching addresses, err_cnt=0. Same run with slave XOR-ing rdata with 1 → err_cnt=4.
- Mode 2, NUM_TRANS=5, TIMEOUT=10, slave never acks → req high exactly 10 cycles then low, timeout=1, trans_cnt=0, done=1; start then re-runs and clears timeout.
- Two runs with the same seed and mode 2 but different ack latencies → identical addr/cmd/wdata sequences; start pulsed while busy → ignored.
